// File: rtl/agat_int_timer_if.sv
// Signal bundle between the Agat-9 CPU glue (master) and the periodic interrupt timer (slave).
interface agat_int_timer_if;
  logic       int_en;
  logic       irq_ack;
  logic       vnmi;
  logic       virq;
  logic       irq_pend;
  logic       overrun;
  logic [7:0] frame_cnt;

  modport master (
    output int_en, irq_ack,
    input  vnmi, virq, irq_pend, overrun, frame_cnt
  );

  modport slave (
    input  int_en, irq_ack,
    output vnmi, virq, irq_pend, overrun, frame_cnt
  );
endinterface

// File: rtl/agat_int_timer.sv
// Periodic interrupt source for the Agat-9 core: 500 Hz level IRQ (virq) and 50 Hz
// NMI pulse (vnmi), gated by int_en, plus frame counter and status for readback.
module agat_int_timer #(
  parameter int CLK_HZ     = 50000000,
  parameter int IRQ_HZ     = 500,
  parameter int NMI_DIV    = 10,
  parameter int PULSE_CLKS = 64
) (
  input  logic             clk,
  input  logic             interreset,
  agat_int_timer_if.slave  bus
);

  localparam int PRESCALE = CLK_HZ / IRQ_HZ;
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int DW = (NMI_DIV > 1) ? $clog2(NMI_DIV) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);
  localparam logic [DW-1:0] D_LAST = DW'(NMI_DIV - 1);
  localparam logic [7:0]    W_LOAD = 8'(PULSE_CLKS - 1);

  typedef enum logic {IRQ_IDLE, IRQ_PEND} irq_st_t;
  typedef enum logic {NMI_IDLE, NMI_LOW}  nmi_st_t;

  logic [PW-1:0] r_pcnt;
  logic [DW-1:0] r_dcnt;
  logic [7:0]    r_frame;
  logic          r_ack_s1, r_ack_s2, r_ack_s3;
  irq_st_t       r_irq_st, w_irq_nx;
  nmi_st_t       r_nmi_st, w_nmi_nx;
  logic [7:0]    r_wcnt, w_wcnt_nx;
  logic          r_virq, r_vnmi, r_overrun;
  logic          w_tick500, w_tick50, w_ack_p, w_ovr_set;

  assign w_tick500 = (r_pcnt == P_LAST);
  assign w_tick50  = w_tick500 & (r_dcnt == D_LAST);
  // r_ack_s1/s2 form the synchronizer; s3 only remembers the previous synced value
  assign w_ack_p   = r_ack_s2 & ~r_ack_s3;

  always_ff @(posedge clk or posedge interreset) begin
    if (interreset) begin
      r_pcnt   <= '0;
      r_dcnt   <= '0;
      r_frame  <= '0;
      r_ack_s1 <= 1'b0;
      r_ack_s2 <= 1'b0;
      r_ack_s3 <= 1'b0;
    end else begin
      r_pcnt   <= w_tick500 ? '0 : r_pcnt + PW'(1);
      if (w_tick500)
        r_dcnt <= (r_dcnt == D_LAST) ? '0 : r_dcnt + DW'(1);
      if (w_tick50)
        r_frame <= r_frame + 8'd1;
      r_ack_s1 <= bus.irq_ack;
      r_ack_s2 <= r_ack_s1;
      r_ack_s3 <= r_ack_s2;
    end
  end

  // IRQ: a new tick beats a same-cycle ack; an acked tick is not an overrun
  always_comb begin
    w_irq_nx  = r_irq_st;
    w_ovr_set = 1'b0;
    if (w_tick500 && bus.int_en) begin
      w_irq_nx  = IRQ_PEND;
      w_ovr_set = (r_irq_st == IRQ_PEND) && !w_ack_p;
    end else if (r_irq_st == IRQ_PEND && (w_ack_p || !bus.int_en)) begin
      w_irq_nx  = IRQ_IDLE;
    end
  end

  always_ff @(posedge clk or posedge interreset) begin
    if (interreset) begin
      r_irq_st  <= IRQ_IDLE;
      r_virq    <= 1'b1;
      r_overrun <= 1'b0;
    end else begin
      r_irq_st <= w_irq_nx;
      r_virq   <= (w_irq_nx != IRQ_PEND);
      if (w_ovr_set)
        r_overrun <= 1'b1;
    end
  end

  // NMI pulse: a tick during LOW reloads the width without releasing vnmi
  always_comb begin
    w_nmi_nx  = r_nmi_st;
    w_wcnt_nx = r_wcnt;
    if (w_tick50 && bus.int_en) begin
      w_nmi_nx  = NMI_LOW;
      w_wcnt_nx = W_LOAD;
    end else if (r_nmi_st == NMI_LOW) begin
      if (r_wcnt == 8'd0)
        w_nmi_nx  = NMI_IDLE;
      else
        w_wcnt_nx = r_wcnt - 8'd1;
    end
  end

  always_ff @(posedge clk or posedge interreset) begin
    if (interreset) begin
      r_nmi_st <= NMI_IDLE;
      r_wcnt   <= 8'd0;
      r_vnmi   <= 1'b1;
    end else begin
      r_nmi_st <= w_nmi_nx;
      r_wcnt   <= w_wcnt_nx;
      r_vnmi   <= (w_nmi_nx != NMI_LOW);
    end
  end

  assign bus.vnmi      = r_vnmi;
  assign bus.virq      = r_virq;
  assign bus.irq_pend  = (r_irq_st == IRQ_PEND);
  assign bus.overrun   = r_overrun;
  assign bus.frame_cnt = r_frame;

endmodule

// File: tb/tb_agat_int_timer.sv
// Randomized and directed bench for agat_int_timer; a cycle-level reference model
// feeds expected outputs into a queue that a negedge monitor checks.
module tb_agat_int_timer;

  localparam int PRESCALE   = 10;
  localparam int NMI_DIV    = 4;
  localparam int PULSE_CLKS = 3;
  localparam int FRAME_CLKS = PRESCALE * NMI_DIV;

  typedef struct packed {
    logic       vnmi;
    logic       virq;
    logic       pend;
    logic       ovr;
    logic [7:0] frame;
  } obs_t;

  logic clk = 1'b0;
  logic interreset;
  agat_int_timer_if bus();

  agat_int_timer #(
    .CLK_HZ(1000), .IRQ_HZ(100), .NMI_DIV(NMI_DIV), .PULSE_CLKS(PULSE_CLKS)
  ) dut (
    .clk(clk),
    .interreset(interreset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: time is the number of clock edges since reset release
  int m_cyc;
  bit m_pend, m_ovr;
  int m_low_until;
  bit m_rst, m_en, m_ack;
  bit ack_hist[1:3];   // ack input as sampled 1, 2, 3 edges ago

  function automatic void model_reset();
    m_cyc       = 0;
    m_pend      = 1'b0;
    m_ovr       = 1'b0;
    m_low_until = 0;
    for (int i = 1; i <= 3; i++) ack_hist[i] = 1'b0;
  endfunction

  function automatic obs_t model_out();
    obs_t o;
    o.vnmi  = !(m_cyc < m_low_until);
    o.virq  = !m_pend;
    o.pend  = m_pend;
    o.ovr   = m_ovr;
    o.frame = 8'((m_cyc / FRAME_CLKS) % 256);
    return o;
  endfunction

  // One clock: advance the model over the edge, then drive the inputs for the next one
  task automatic step(input bit rst_v, input bit en_v, input bit ack_v);
    bit tick500, tick50, ack_rise;
    @(posedge clk);
    #1;
    if (!m_rst) begin
      m_cyc++;
      tick500  = (m_cyc % PRESCALE) == 0;
      tick50   = tick500 && ((m_cyc % FRAME_CLKS) == 0);
      ack_rise = ack_hist[2] && !ack_hist[3];
      ack_hist[3] = ack_hist[2];
      ack_hist[2] = ack_hist[1];
      ack_hist[1] = m_ack;
      if (tick500 && m_en) begin
        if (m_pend && !ack_rise) m_ovr = 1'b1;
        m_pend = 1'b1;
      end else if (ack_rise || !m_en) begin
        m_pend = 1'b0;
      end
      if (tick50 && m_en) m_low_until = m_cyc + PULSE_CLKS;
    end
    interreset  = rst_v;
    bus.int_en  = en_v;
    bus.irq_ack = ack_v;
    m_rst = rst_v;
    m_en  = en_v;
    m_ack = ack_v;
    if (rst_v) model_reset();
    exp_q.push_back(model_out());
  endtask

  task automatic do_reset(input bit en_v);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, en_v, 1'b0);
  endtask

  always @(negedge clk) begin
    obs_t e, g;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = '{bus.vnmi, bus.virq, bus.irq_pend, bus.overrun, bus.frame_cnt};
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL outputs t=%0t: got vnmi=%b virq=%b pend=%b ovr=%b frame=%0d, expected vnmi=%b virq=%b pend=%b ovr=%b frame=%0d",
                 $time, g.vnmi, g.virq, g.pend, g.ovr, g.frame,
                 e.vnmi, e.virq, e.pend, e.ovr, e.frame);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running, required finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int ack_left, rst_left;
    bit en_r;
    interreset  = 1'b1;
    bus.int_en  = 1'b0;
    bus.irq_ack = 1'b0;
    m_rst = 1'b1; m_en = 1'b0; m_ack = 1'b0;
    model_reset();

    // free run with interrupts enabled and no ack: overrun and first NMI pulse
    do_reset(1'b1);
    repeat (50) step(1'b0, 1'b1, 1'b0);

    // single-cycle ack two clocks after virq falls
    do_reset(1'b1);
    repeat (30) step(1'b0, 1'b1, (m_cyc + 1) == 12);

    // ack pulse arriving on the same clock as the next tick, held high for several clocks
    do_reset(1'b1);
    repeat (40) step(1'b0, 1'b1, (m_cyc + 1) >= 17 && (m_cyc + 1) <= 21);

    // interrupts disabled: frame counter runs past its wrap
    do_reset(1'b0);
    repeat (10300) step(1'b0, 1'b0, 1'b0);

    // int_en dropped during the NMI pulse
    do_reset(1'b1);
    repeat (50) step(1'b0, (m_cyc + 1) < 41, 1'b0);

    // reset asserted mid-pulse with IRQ pending
    do_reset(1'b1);
    while (m_cyc < 40) step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    repeat (30) step(1'b0, 1'b1, 1'b0);

    // randomized enable, ack pulses and occasional resets
    do_reset(1'b1);
    en_r = 1'b1;
    ack_left = 0;
    rst_left = 0;
    repeat (4000) begin
      if ($urandom_range(0, 49) == 0) en_r = !en_r;
      if (ack_left > 0) ack_left--;
      else if ($urandom_range(0, 14) == 0) ack_left = $urandom_range(1, 6);
      if (rst_left > 0) rst_left--;
      else if ($urandom_range(0, 599) == 0) rst_left = $urandom_range(1, 3);
      step(rst_left > 0, en_r, ack_left > 0);
    end

    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
